// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the two-requester multiplier scheduler.
// State encoding, requester count and default watchdog limit live here.
package mult_sched_pkg;

    localparam int NUM_REQ                = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Index of the owner named by a one-hot two-bit grant.
    function automatic logic owner_idx(input logic [NUM_REQ-1:0] g);
        return g[1];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: pointer names the preferred requester,
// a lone request always wins.
module rr_arb2
    import mult_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               pointer,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mult_sched.sv
// Scheduler granting a shared multiplier datapath to one of two requesters.
// Optional watchdog on the WAIT state is enabled by MULT_SCHED_TIMEOUT_EN.
//
// Handshake: req is a level held by a requester wanting service; grant and
// dp_sel name the owner from IDLE exit until RESP; dp_start pulses once in
// LAUNCH; a job completes on a rising edge of dp_done seen in WAIT; ack pulses
// one cycle for the owner in RESP, with err alongside when the job timed out.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic               err,
    output logic [NUM_REQ-1:0] grant,
    output logic               dp_start,
    output logic               dp_sel,
    input  logic               dp_done,
    output logic               busy,
    output state_t             state
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    logic               pointer;
    logic               done_q;
    logic               done_edge;
    logic [NUM_REQ-1:0] arb_grant;

    rr_arb2 u_arb (
        .req     (req),
        .pointer (pointer),
        .grant   (arb_grant)
    );

    // done_q resets high so a done level present at startup is not an edge.
    assign done_edge = dp_done & ~done_q;
    assign busy      = (state != IDLE);

`ifdef MULT_SCHED_TIMEOUT_EN
    logic [7:0] wdog;
    logic       err_q;
    logic       timed_out;

    assign timed_out = (wdog == 8'(TIMEOUT_CYCLES - 1));
    assign err       = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pointer  <= 1'b0;
            grant    <= '0;
            dp_sel   <= 1'b0;
            ack      <= '0;
            dp_start <= 1'b0;
            done_q   <= 1'b1;
`ifdef MULT_SCHED_TIMEOUT_EN
            err_q    <= 1'b0;
            wdog     <= 8'd0;
`endif
        end else begin
            done_q   <= dp_done;
            ack      <= '0;
            dp_start <= 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= arb_grant;
                        dp_sel   <= owner_idx(arb_grant);
                        dp_start <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
`ifdef MULT_SCHED_TIMEOUT_EN
                    wdog  <= 8'd0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_edge) begin
                        ack   <= grant;
                        state <= RESP;
                    end
`ifdef MULT_SCHED_TIMEOUT_EN
                    else if (timed_out) begin
                        ack   <= grant;
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
`endif
                end
                RESP: begin
                    // The non-owner becomes preferred for the next arbitration.
                    pointer <= ~owner_idx(grant);
                    grant   <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// Randomized scoreboard bench for mult_sched; covers the timeout path when
// MULT_SCHED_TIMEOUT_EN is defined.
module tb_mult_sched;
    import mult_sched_pkg::*;

    localparam int TMO = 4;
`ifdef MULT_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] ack;
    logic       err;
    logic [1:0] grant;
    logic       dp_start;
    logic       dp_sel;
    logic       dp_done;
    logic       busy;
    state_t     state;

    mult_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .ack      (ack),
        .err      (err),
        .grant    (grant),
        .dp_start (dp_start),
        .dp_sel   (dp_sel),
        .dp_done  (dp_done),
        .busy     (busy),
        .state    (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // entry: {ack cycle[34:3], owner one-hot[2:1], err[0]}
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;
    logic        exp_ptr;      // preferred requester = the one not served last
    int          tests = 0;
    int          fails = 0;
    int          start_cyc = 0;
    int          last_ack_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && ack !== 2'b00) begin
            last_ack_cyc = cyc;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: ack=%b with nothing expected (cycle %0d)", ack, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_cycle", 32'(cyc), mon_e[34:3]);
                check("ack_owner", 32'(ack), 32'(mon_e[2:1]));
                check("ack_err", 32'(err), 32'(mon_e[0]));
                check("ack_in_resp", 32'(state), 32'(RESP));
            end
        end
        if (dp_start) check("dp_start_in_launch", 32'(state == LAUNCH), 32'd1);
        if (err) check("err_with_ack", 32'(|ack), 32'd1);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    // One job: r sampled in IDLE, dp_done rises d cycles after the dp_start
    // cycle (never if the watchdog fires first).
    task automatic run_job(input logic [1:0] r, input int d, input bit drop, input bit hi_first);
        int         w;
        int         dd;
        logic [1:0] oh;
        logic       e_err;
        wait_idle();
        req   = r;
        w     = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : int'(exp_ptr);
        oh    = (w == 0) ? 2'b01 : 2'b10;
        e_err = TMO_EN && (d > TMO);
        dd    = e_err ? TMO : d;
        exp_q.push_back({32'(cyc + 2 + dd), oh, e_err});
        exp_ptr = (w == 0);
        @(negedge clk);
        start_cyc = cyc;
        check("dp_start", 32'(dp_start), 32'd1);
        check("grant", 32'(grant), 32'(oh));
        check("dp_sel", 32'(dp_sel), 32'(w));
        check("busy_launch", 32'(busy), 32'd1);
        if (!hi_first) dp_done = 1'b0;
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            if (ack !== 2'b00) break;
            if (k == 1) begin
                check("dp_start_one_cycle", 32'(dp_start), 32'd0);
                if (drop) req[w] = 1'b0;
            end
            if (hi_first && k == 2) dp_done = 1'b0;
            if (k == d) dp_done = 1'b1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        req     = 2'b00;
        dp_done = 1'b0;
        reset   = 1'b1;
        exp_ptr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_dp_sel", 32'(dp_sel), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dp_start", 32'(dp_start), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // both requesting from reset: 0 first, then 1 after a single IDLE cycle
        run_job(2'b11, 5, 1'b0, 1'b0);
        run_job(2'b11, 2, 1'b0, 1'b0);
        check("rr_gap", 32'(start_cyc - last_ack_cyc), 32'd2);

        // lone request 0, done rising 5 cycles after dp_start
        run_job(2'b01, 5, 1'b0, 1'b0);

        // done left high: only the later rising edge completes
        run_job(2'b01, 2, 1'b0, 1'b0);
        run_job(2'b10, 5, 1'b0, 1'b1);

        // owner 1 drops req during WAIT
        run_job(2'b10, 4, 1'b1, 1'b0);

`ifdef MULT_SCHED_TIMEOUT_EN
        // done stuck low: watchdog ends the job with err
        run_job(2'b01, 1000, 1'b0, 1'b0);
        wait_idle();
        check("tmo_back_idle", 32'(state), 32'(IDLE));
`endif

        // reset during WAIT abandons the job
        wait_idle();
        req = 2'b01;
        @(negedge clk);
        check("rst_job_start", 32'(dp_start), 32'd1);
        dp_done = 1'b0;
        @(negedge clk);
        check("rst_job_wait", 32'(state), 32'(WAIT));
        reset = 1'b1;
        @(negedge clk);
        check("rstw_state", 32'(state), 32'(IDLE));
        check("rstw_grant", 32'(grant), 32'd0);
        check("rstw_dp_sel", 32'(dp_sel), 32'd0);
        check("rstw_dp_start", 32'(dp_start), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        reset   = 1'b0;
        req     = 2'b00;
        exp_ptr = 1'b0;
        dp_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstw_no_ack", 32'(ack), 32'd0);
            check("rstw_err", 32'(err), 32'd0);
        end

        // randomized traffic
        for (int j = 0; j < 30; j++) begin
            int idle_n;
            wait_idle();
            idle_n = $urandom_range(0, 2);
            req = 2'b00;
            for (int i = 0; i < idle_n; i++) begin
                @(negedge clk);
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_grant", 32'(grant), 32'd0);
            end
            run_job(2'($urandom_range(1, 3)), $urandom_range(1, 8),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
